// File: rtl/mms_pkg.sv
// Shared constants, select encoding and FSM state type for the mms_stream
// max/min frame search block.
package mms_pkg;

  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 256;
  localparam int CNT_W   = 9;
  localparam int IDX_W   = 8;

  localparam logic SEL_MAX = 1'b0;
  localparam logic SEL_MIN = 1'b1;

  // Count value held while the final (256th) beat of a full frame is offered.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/mms_cmp.sv
// Combinational unsigned compare-and-select: picks cand over cur only on a
// strict win (greater for max, less for min) so ties keep the incumbent.
module mms_cmp
  import mms_pkg::*;
(
  input  logic              sel,
  input  logic [DATA_W-1:0] cur,
  input  logic [DATA_W-1:0] cand,
  output logic [DATA_W-1:0] result,
  output logic              replace
);

  always_comb begin
    replace = (sel == SEL_MIN) ? (cand < cur) : (cand > cur);
    result  = replace ? cand : cur;
  end

endmodule

// File: rtl/mms_stream.sv
// Streaming frame max/min search with valid/ready handshakes on both sides.
// Optional MMS_STREAM_INDEX_EN adds out_index, the position of the winner.
module mms_stream
  import mms_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              select,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef MMS_STREAM_INDEX_EN
  output logic [IDX_W-1:0]  out_index,
`endif
  output logic [DATA_W-1:0] out_result,
  output logic [CNT_W-1:0]  out_count
);

  state_t             state;
  state_t             state_nx;
  logic               accept;
  logic               sel_q;
  logic [DATA_W-1:0]  run_val;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  cmp_result;
  logic               cmp_replace;

  assign accept = in_valid && in_ready;

  mms_cmp u_cmp (
    .sel     (sel_q),
    .cur     (run_val),
    .cand    (in_data),
    .result  (cmp_result),
    .replace (cmp_replace)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = in_last ? OUT : ACC;
      ACC:  if (accept && (in_last || count == LAST_CNT)) state_nx = OUT;
      OUT:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state != OUT);
    out_valid = (state == OUT);
  end

  // Running value, frame length and latched mode; frozen while in OUT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_val <= '0;
      count   <= '0;
      sel_q   <= SEL_MAX;
    end else if (accept) begin
      if (state == IDLE) begin
        run_val <= in_data;
        count   <= CNT_W'(1);
        sel_q   <= select;
      end else begin
        run_val <= cmp_result;
        count   <= count + 1'b1;
      end
    end
  end

  assign out_result = run_val;
  assign out_count  = count;

`ifdef MMS_STREAM_INDEX_EN
  logic [IDX_W-1:0] idx;

  // In ACC the current count equals the 0-based position of the incoming beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (accept) begin
      if (state == IDLE)    idx <= '0;
      else if (cmp_replace) idx <= count[IDX_W-1:0];
    end
  end

  assign out_index = idx;
`endif

endmodule

// File: tb/tb_mms_stream.sv
// Self-checking bench for mms_stream: frame-level queue model plus directed
// literal cases and randomized frames with gaps and output back-pressure.
module tb_mms_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       select = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_result;
  logic [8:0] out_count;
`ifdef MMS_STREAM_INDEX_EN
  logic [7:0] out_index;
`endif

  mms_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .select     (select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef MMS_STREAM_INDEX_EN
    .out_index  (out_index),
`endif
    .out_result (out_result),
    .out_count  (out_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: collect accepted beats, evaluate the frame when it closes.
  logic [7:0] fq[$];
  bit         fsel = 1'b0;
  bit         m_out = 1'b0;
  bit         started = 1'b0;
  logic [7:0] e_res = 8'd0;
  logic [8:0] e_cnt = 9'd0;
  logic [7:0] e_idx = 8'd0;

  always @(posedge clk) begin
    started = 1'b1;
    if (!rst_n) begin
      fq.delete();
      m_out = 1'b0;
    end else if (m_out) begin
      if (out_ready) m_out = 1'b0;
    end else if (in_valid) begin
      if (fq.size() == 0) fsel = select;
      fq.push_back(in_data);
      if (in_last || fq.size() == 256) begin
        e_res = fq[0];
        e_idx = 8'd0;
        for (int i = 1; i < fq.size(); i++) begin
          if (fsel ? (fq[i] < e_res) : (fq[i] > e_res)) begin
            e_res = fq[i];
            e_idx = 8'(i);
          end
        end
        e_cnt = 9'(fq.size());
        fq.delete();
        m_out = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("in_ready", in_ready, !m_out);
      check("out_valid", out_valid, m_out);
      if (m_out) begin
        check("out_result", out_result, e_res);
        check("out_count", out_count, e_cnt);
`ifdef MMS_STREAM_INDEX_EN
        check("out_index", out_index, e_idx);
`endif
      end
    end
  end

  bit rand_ready = 1'b0;
  always @(posedge clk) begin
    #2;
    if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic gap(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
      in_data = 8'($urandom);
      in_last = 1'($urandom);
      select  = 1'($urandom);
    end
  endtask

  // Called at posedge+2; returns at posedge+2 after the beat is taken.
  task automatic send_beat(input logic [7:0] d, input logic l, input logic s);
    logic rdy;
    int   n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    select   = s;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #2;
      n++;
      if (rdy) break;
      if (n >= 200) begin
        check("send_beat timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
    select   = 1'($urandom);
  endtask

  task automatic expect_out(input string name, input logic [7:0] r, input logic [8:0] c,
                            input logic [7:0] ix, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    check({name, " valid"}, out_valid, 1);
    check({name, " result"}, out_result, r);
    check({name, " count"}, out_count, c);
`ifdef MMS_STREAM_INDEX_EN
    check({name, " index"}, out_index, ix);
`else
    if (ix != 8'd0 && ix == 8'd255) $display("index %0d", ix);
`endif
    @(posedge clk);
    #2;
  endtask

  initial begin
    int lat;
    int len;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset out_result", out_result, 0);
    check("reset out_count", out_count, 0);
    check("reset in_ready", in_ready, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    gap(2);

    // max with a tie: earliest 200 (position 1) is kept
    send_beat(8'd3, 1'b0, 1'b0);
    send_beat(8'd200, 1'b0, 1'b0);
    send_beat(8'd17, 1'b0, 1'b0);
    send_beat(8'd200, 1'b1, 1'b0);
    expect_out("t030", 8'd200, 9'd4, 8'd1, lat);

    send_beat(8'd42, 1'b1, 1'b1);
    expect_out("t031", 8'd42, 9'd1, 8'd0, lat);
    check("t031 latency", lat, 1);

    for (int i = 0; i < 256; i++) send_beat(8'(i), 1'b0, 1'b1);
    expect_out("t032", 8'd0, 9'd256, 8'd0, lat);
    check("t032 latency", lat, 1);

    // held output with a beat offered during OUT that must not be taken
    out_ready = 1'b0;
    send_beat(8'd7, 1'b0, 1'b0);
    send_beat(8'd3, 1'b1, 1'b0);
    expect_out("t033", 8'd7, 9'd2, 8'd0, lat);
    in_valid = 1'b1;
    in_data  = 8'd99;
    in_last  = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    send_beat(8'd1, 1'b0, 1'b1);
    send_beat(8'd2, 1'b1, 1'b1);
    expect_out("t033b", 8'd1, 9'd2, 8'd0, lat);

    // select flips after first beat, gaps between beats
    send_beat(8'd10, 1'b0, 1'b0);
    gap(3);
    send_beat(8'd50, 1'b0, 1'b1);
    gap(1);
    send_beat(8'd5, 1'b1, 1'b1);
    expect_out("t034", 8'd50, 9'd3, 8'd1, lat);

    // reset mid-frame discards the partial frame
    send_beat(8'd100, 1'b0, 1'b1);
    send_beat(8'd200, 1'b0, 1'b1);
    send_beat(8'd150, 1'b0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    gap(3);
    @(negedge clk);
    check("t035 no output", out_valid, 0);
    @(posedge clk);
    #2;
    send_beat(8'd5, 1'b0, 1'b0);
    send_beat(8'd9, 1'b1, 1'b0);
    expect_out("t035", 8'd9, 9'd2, 8'd1, lat);

    // randomized frames with back-pressure, gaps and narrow data for ties
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
        send_beat((f % 2) ? 8'($urandom_range(0, 3)) : 8'($urandom),
                  (k == len - 1), 1'($urandom));
      end
    end
    rand_ready = 1'b0;
    #1;
    out_ready = 1'b1;
    gap(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end

endmodule
